// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared widths, period length and types for ultrasound_pwm_generator
// Revision : 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;
    localparam int CNT_WIDTH  = 9;
    localparam int DUTY_WIDTH = 8;
    localparam int CYCLE      = 2 ** CNT_WIDTH;
    localparam int C_SHIFT    = CNT_WIDTH - DUTY_WIDTH;

    typedef logic [CNT_WIDTH-1:0]  cnt_t;
    typedef logic [DUTY_WIDTH-1:0] duty_t;
endpackage

`default_nettype wire

// File: rtl/ultrasound_pwm_generator_if.sv
// ============================================================================
// ultrasound_pwm_generator_if : per-transducer PWM control/drive bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ultrasound_pwm_generator_if;
    import pwm_pkg::*;

    cnt_t  TIME;
    duty_t DUTY;
    duty_t PHASE;
    logic  DUTY_OFFSET;
    logic  PWM_OUT;

    modport master (output TIME, DUTY, PHASE, DUTY_OFFSET, input PWM_OUT);
    modport slave  (input TIME, DUTY, PHASE, DUTY_OFFSET, output PWM_OUT);
endinterface

`default_nettype wire

// File: rtl/ultrasound_pwm_generator_edge_calc.sv
// ============================================================================
// pwm_edge_calc : combinational rise/fall tick and enable from DUTY/PHASE
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_edge_calc
    import pwm_pkg::*;
(
    input  wire duty_t i_duty,
    input  wire duty_t i_phase,
    input  wire logic  i_duty_offset,
    output cnt_t       o_t_s,
    output cnt_t       o_t_e,
    output logic       o_en
);
    cnt_t w_width;
    cnt_t w_centre;
    cnt_t w_half_lo;
    cnt_t w_half_hi;

    // Width peaks at half a period, so W+1 still fits and the split never wraps.
    assign w_width   = cnt_t'(i_duty) + cnt_t'(i_duty_offset);
    assign w_centre  = cnt_t'(i_phase) << C_SHIFT;
    assign w_half_lo = w_width >> 1;
    assign w_half_hi = (w_width + cnt_t'(1)) >> 1;

    assign o_t_s = w_centre - w_half_lo;
    assign o_t_e = w_centre + w_half_hi;
    assign o_en  = |i_duty;
endmodule

`default_nettype wire

// File: rtl/ultrasound_pwm_generator.sv
// ============================================================================
// ultrasound_pwm_generator : PWM pulse centred on PHASE, width DUTY+DUTY_OFFSET.
// Option macro PWM_PERIOD_LATCH_EN: edges reload only at TIME == CYCLE-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ultrasound_pwm_generator
    import pwm_pkg::*;
(
    input  wire logic                  CLK,
    input  wire logic                  RST,
    ultrasound_pwm_generator_if.slave  bus
);
    cnt_t w_calc_t_s;
    cnt_t w_calc_t_e;
    logic w_calc_en;
    logic w_load;
    logic w_hit;

    cnt_t t_s_q, t_s_d;
    cnt_t t_e_q, t_e_d;
    logic en_q,  en_d;
    logic pwm_q, pwm_d;

    pwm_edge_calc u_edge_calc (
        .i_duty        (bus.DUTY),
        .i_phase       (bus.PHASE),
        .i_duty_offset (bus.DUTY_OFFSET),
        .o_t_s         (w_calc_t_s),
        .o_t_e         (w_calc_t_e),
        .o_en          (w_calc_en)
    );

    always_comb begin
`ifdef PWM_PERIOD_LATCH_EN
        w_load = (bus.TIME == cnt_t'(CYCLE - 1));
`else
        w_load = 1'b1;
`endif
        t_s_d = t_s_q;
        t_e_d = t_e_q;
        en_d  = en_q;
        if (w_load) begin
            t_s_d = w_calc_t_s;
            t_e_d = w_calc_t_e;
            en_d  = w_calc_en;
        end

        // Fall before rise means the window straddles the period boundary.
        if (t_s_q <= t_e_q) begin
            w_hit = (bus.TIME >= t_s_q) && (bus.TIME < t_e_q);
        end else begin
            w_hit = (bus.TIME >= t_s_q) || (bus.TIME < t_e_q);
        end
        pwm_d = en_q & w_hit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            t_s_q <= '0;
            t_e_q <= '0;
            en_q  <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            t_s_q <= t_s_d;
            t_e_q <= t_e_d;
            en_q  <= en_d;
            pwm_q <= pwm_d;
        end
    end

    assign bus.PWM_OUT = pwm_q;
endmodule

`default_nettype wire

// File: tb/tb_ultrasound_pwm_generator.sv
// ============================================================================
// tb_ultrasound_pwm_generator : directed + randomized check against a window model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ultrasound_pwm_generator;
    import pwm_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    ultrasound_pwm_generator_if bus ();

    ultrasound_pwm_generator dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Model: settings currently in force, as pulse start and length in ticks.
    bit m_en    = 1'b0;
    int m_start = 0;
    int m_w     = 0;
    bit obs [CYCLE];

`ifdef PWM_PERIOD_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int mod_cycle(input int x);
        return ((x % CYCLE) + CYCLE) % CYCLE;
    endfunction

    // One clock: drive inputs, advance the model, compare the registered output.
    task automatic step(input bit r, input int t, input int d, input int p, input bit o);
        bit exp;
        RST             = r;
        bus.TIME        = cnt_t'(t);
        bus.DUTY        = duty_t'(d);
        bus.PHASE       = duty_t'(p);
        bus.DUTY_OFFSET = o;
        @(posedge CLK);
        exp = !r && m_en && (mod_cycle(t - m_start) < m_w);
        if (r) begin
            m_en = 1'b0;
        end else if (!LATCH || t == CYCLE - 1) begin
            m_en    = (d != 0);
            m_w     = d + int'(o);
            m_start = mod_cycle(p * (1 << C_SHIFT) - m_w / 2);
        end
        #1;
        check($sformatf("pwm_out t=%0d duty=%0d phase=%0d", t, d, p), int'(bus.PWM_OUT), int'(exp));
        obs[t] = bus.PWM_OUT;
    endtask

    task automatic run_period(input int d, input int p);
        for (int t = 0; t < CYCLE; t++) step(1'b0, t, d, p, 1'b1);
    endtask

    task automatic settle(input int d, input int p);
        run_period(d, p);
        run_period(d, p);
    endtask

    task automatic lit(input string name, input int idx, input int exp);
        check(name, int'(obs[idx]), exp);
    endtask

    task automatic expect_count(input string name, input int exp);
        int n;
        n = 0;
        for (int i = 0; i < CYCLE; i++) n += int'(obs[i]);
        check(name, n, exp);
    endtask

    initial begin
        int t;
        int d;
        int p;
        bit o;

        for (int i = 0; i < 4; i++) step(1'b1, 508 + i, 255, 50, 1'b1);
        check("reset_out", int'(bus.PWM_OUT), 0);

        settle(255, 50);
        expect_count("w256_count", 256);
        lit("w256_rise", 484, 1);
        lit("w256_pre", 483, 0);
        lit("w256_last", 227, 1);
        lit("w256_fall", 228, 0);

        settle(240, 60);
        expect_count("w241_count", 241);
        lit("w241_first", 0, 1);
        lit("w241_last", 240, 1);
        lit("w241_fall", 241, 0);
        lit("w241_prev", 511, 0);

        settle(250, 50);
        lit("w251a_rise", 487, 1);
        lit("w251a_pre", 486, 0);
        lit("w251a_fall", 226, 0);

        settle(250, 200);
        expect_count("wrap_count", 251);
        lit("wrap_rise", 275, 1);
        lit("wrap_pre", 274, 0);
        lit("wrap_last", 13, 1);
        lit("wrap_fall", 14, 0);

        // Switch settings at TIME=100 while the wrap window is active.
        for (int i = 0; i < CYCLE; i++) begin
            if (i < 100) step(1'b0, i, 250, 200, 1'b1);
            else         step(1'b0, i, 255, 50, 1'b1);
        end
        lit("midchange_t150", 150, LATCH ? 0 : 1);
        run_period(255, 50);
        lit("midchange_next", 150, 1);

        settle(0, 0);
        expect_count("off_phase0", 0);
        settle(0, 255);
        expect_count("off_phase255", 0);

        settle(255, 0);
        lit("c0_rise", 384, 1);
        lit("c0_pre", 383, 0);
        lit("c0_last", 127, 1);
        lit("c0_fall", 128, 0);
        expect_count("c0_count", 256);

        for (int i = 0; i < 50; i++) step(1'b0, i, 255, 0, 1'b1);
        step(1'b1, 50, 255, 0, 1'b1);
        check("reset_midperiod", int'(bus.PWM_OUT), 0);
        for (int i = 51; i < CYCLE; i++) step(1'b0, i, 255, 0, 1'b1);
        run_period(255, 0);

        t = 0;
        d = 128;
        p = 128;
        o = 1'b1;
        for (int n = 0; n < 8000; n++) begin
            if ($urandom_range(63) == 0) begin
                d = $urandom_range(255);
                p = $urandom_range(255);
                o = ($urandom_range(7) != 0);
                if ($urandom_range(7) == 0) d = 0;
            end
            if ($urandom_range(199) == 0) t = $urandom_range(CYCLE - 1);
            step($urandom_range(499) == 0, t, d, p, o);
            t = (t + 1) % CYCLE;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
